// File: rtl/alu_access_arbiter_if.sv
// Handshake bundle between the requester front-ends (master) and the ALU access arbiter (slave).
interface alu_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0] req_async;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               alu_ena;
  logic [NUM_REQ-1:0] ack;
  logic               busy;

  modport master (output req_async, input grant, grant_id, alu_ena, ack, busy);
  modport slave  (input req_async, output grant, grant_id, alu_ena, ack, busy);
endinterface

// File: rtl/alu_access_arbiter.sv
// Round-robin owner of the shared 74181 ALU datapath: resynchronises 4-phase
// requests, grants one requester at a time, strobes the ALU, then acknowledges.
module alu_access_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int OP_CYCLES   = 2,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W      = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                ena,
  alu_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_e;

  state_e                               state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_REQ-1:0]  sync_q;
  logic [NUM_REQ-1:0]                   req_sync;
  logic [ID_W-1:0]                      ptr_q, ptr_d, ptr_inc;
  logic [ID_W-1:0]                      win_id;
  logic                                 win_valid;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]                   grant_q, grant_d;
  logic [NUM_REQ-1:0]                   ack_q, ack_d;
  logic [ID_W-1:0]                      gid_q, gid_d;
  logic                                 alu_ena_q, alu_ena_d;
  logic                                 busy_q, busy_d;

  assign req_sync = sync_q[SYNC_STAGES-1];

  // Stage 0 samples the raw request; the highest stage feeds every FSM decision.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '0;
    end else if (ena) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_async};
    end
  end

  // First pending request scanning upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_valid = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_valid && req_sync[idx]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign ptr_inc = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + ID_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    gid_d     = gid_q;
    alu_ena_d = alu_ena_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d   = GRANT;
          grant_d   = NUM_REQ'(1) << win_id;
          gid_d     = win_id;
          alu_ena_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = CNT_W'(OP_CYCLES - 1);
        end
      end
      GRANT: begin
        if (cnt_q == '0) begin
          state_d   = ACK;
          alu_ena_d = 1'b0;
          ack_d     = grant_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        // grant_id is kept so it still names the last owner while idle.
        if (!req_sync[gid_q]) begin
          state_d = IDLE;
          ack_d   = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      gid_q     <= '0;
      alu_ena_q <= 1'b0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      gid_q     <= gid_d;
      alu_ena_q <= alu_ena_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = gid_q;
  assign bus.alu_ena  = alu_ena_q;
  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_alu_access_arbiter.sv
// Scoreboard bench for alu_access_arbiter: expected owners are queued as requests
// are raised and compared as grants appear; latencies and invariants checked each step.
module tb_alu_access_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int SYNC_STAGES = 2;
  localparam int OP_CYCLES   = 2;

  logic clk = 1'b0;
  logic rstb;
  logic ena;
  int   checks   = 0;
  int   failures = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  alu_access_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  alu_access_arbiter #(
    .NUM_REQ(NUM_REQ), .SYNC_STAGES(SYNC_STAGES), .OP_CYCLES(OP_CYCLES)
  ) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .bus(bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.grant, bus.grant_id, bus.alu_ena, bus.ack, bus.busy});
  endfunction

  // Protocol invariants on every cycle outside reset.
  always @(negedge clk) begin
    if (rstb) begin
      check_eq("inv_onehot", 32'($onehot0(bus.grant) && $onehot0(bus.ack)), 1);
      check_eq("inv_ack_eq_grant", 32'(bus.ack == '0 || bus.ack == bus.grant), 1);
      check_eq("inv_alu_ena_in_grant", 32'(!bus.alu_ena || (bus.grant != '0 && bus.ack == '0)), 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected done", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic reset_pulse(input string tag);
    #2 rstb = 1'b0;
    #1;
    check_eq({tag, ":grant"},    32'(bus.grant), 0);
    check_eq({tag, ":ack"},      32'(bus.ack), 0);
    check_eq({tag, ":alu_ena"},  32'(bus.alu_ena), 0);
    check_eq({tag, ":busy"},     32'(bus.busy), 0);
    check_eq({tag, ":grant_id"}, 32'(bus.grant_id), 0);
    tick();
  endtask

  // Plays one requester through a full handshake against the next scoreboard entry.
  task automatic serve(input string tag, input int exp_lat, input int drop_delay,
                       input int gate, input bit violate, input bit reraise);
    int n, id, ena_cnt, g2a, rel, g;
    logic [31:0] snap;
    n = 0;
    while (bus.grant == '0 && n < 50) begin tick(); n++; end
    check_eq({tag, ":granted"}, 32'(bus.grant != '0), 1);
    if (exp_lat >= 0) check_eq({tag, ":latency"}, n, exp_lat);
    check_eq({tag, ":sb_size"}, 32'(exp_q.size() > 0), 1);
    id = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    check_eq({tag, ":grant_id"}, 32'(bus.grant_id), id);
    check_eq({tag, ":grant"},    32'(bus.grant), 32'(1) << id);
    check_eq({tag, ":alu_ena"},  32'(bus.alu_ena), 1);
    check_eq({tag, ":busy"},     32'(bus.busy), 1);
    if (violate) bus.req_async[id] = 1'b0;
    g = gate; ena_cnt = 0; g2a = 0;
    while (bus.ack == '0 && g2a < 50) begin
      if (g > 0 && bus.alu_ena) begin
        snap = outs();
        ena = 1'b0;
        repeat (g) begin
          tick(); g2a++;
          check_eq({tag, ":frozen"}, outs(), snap);
        end
        ena = 1'b1; g = 0;
      end
      if (bus.alu_ena) ena_cnt++;
      tick(); g2a++;
    end
    check_eq({tag, ":alu_cycles"},   ena_cnt, OP_CYCLES);
    check_eq({tag, ":grant_to_ack"}, g2a, OP_CYCLES + gate);
    check_eq({tag, ":ack"},          32'(bus.ack), 32'(1) << id);
    check_eq({tag, ":alu_ena_ack"},  32'(bus.alu_ena), 0);
    repeat (drop_delay) tick();
    check_eq({tag, ":ack_hold"}, 32'(bus.ack), 32'(1) << id);
    bus.req_async[id] = 1'b0;
    rel = 0;
    while (bus.ack != '0 && rel < 50) begin tick(); rel++; end
    check_eq({tag, ":release"},  rel, violate ? 1 : SYNC_STAGES + 1);
    check_eq({tag, ":grant_rel"}, 32'(bus.grant), 0);
    check_eq({tag, ":busy_rel"},  32'(bus.busy), 0);
    check_eq({tag, ":id_hold"},   32'(bus.grant_id), id);
    $display("txn %s: id=%0d lat=%0d grant_to_ack=%0d alu_cycles=%0d release=%0d",
             tag, id, n, g2a, ena_cnt, rel);
    if (reraise) bus.req_async[id] = 1'b1;
  endtask

  initial begin
    int n;
    int id;
    rstb = 1'b0;
    ena  = 1'b1;
    bus.req_async = 4'hF;
    repeat (3) tick();
    check_eq("rst:grant",    32'(bus.grant), 0);
    check_eq("rst:ack",      32'(bus.ack), 0);
    check_eq("rst:alu_ena",  32'(bus.alu_ena), 0);
    check_eq("rst:busy",     32'(bus.busy), 0);
    check_eq("rst:grant_id", 32'(bus.grant_id), 0);
    rstb = 1'b1;
    exp_q.push_back(0);
    tick(); tick();
    check_eq("rst:grant_c2", 32'(bus.grant), 0);
    tick();
    check_eq("rst:grant_c3", 32'(bus.grant), 4'b0001);

    // Round robin with every line requesting continuously.
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
    for (int i = 0; i < 5; i++) serve($sformatf("rr%0d", i), -1, 0, 0, 1'b0, 1'b1);
    bus.req_async = '0;
    reset_pulse("rst_idle");
    rstb = 1'b1;
    tick();

    // Single requester with the requester holding req 3 cycles into ACK.
    bus.req_async[2] = 1'b1; exp_q.push_back(2);
    serve("single2", SYNC_STAGES + 1, 3, 0, 1'b0, 1'b0);

    // Pointer wrap: 3 served, then 0 and 2 together.
    bus.req_async[3] = 1'b1; exp_q.push_back(3);
    serve("wrap3", SYNC_STAGES + 1, 0, 0, 1'b0, 1'b0);
    bus.req_async[0] = 1'b1; bus.req_async[2] = 1'b1;
    exp_q.push_back(0); exp_q.push_back(2);
    serve("wrap0", SYNC_STAGES + 1, 0, 0, 1'b0, 1'b0);
    serve("wrap2", -1, 0, 0, 1'b0, 1'b0);

    // Clock enable dropped for 5 cycles during GRANT.
    bus.req_async[1] = 1'b1; exp_q.push_back(1);
    serve("gate1", SYNC_STAGES + 1, 0, 5, 1'b0, 1'b0);

    // Requester drops early during GRANT.
    bus.req_async[2] = 1'b1; exp_q.push_back(2);
    serve("viol2", SYNC_STAGES + 1, 0, 0, 1'b1, 1'b0);

    // Reset while requester 3 sits in ACK; it keeps requesting afterwards.
    bus.req_async[3] = 1'b1; exp_q.push_back(3);
    n = 0;
    while (bus.ack == '0 && n < 50) begin tick(); n++; end
    id = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    check_eq("ackrst:grant_id", 32'(bus.grant_id), id);
    check_eq("ackrst:ack", 32'(bus.ack), 32'(1) << id);
    $display("txn ackrst: id=%0d reached ACK after %0d cycles, reset applied", id, n);
    reset_pulse("rst_ack");
    rstb = 1'b1;
    bus.req_async[0] = 1'b1;
    exp_q.push_back(0); exp_q.push_back(3);
    serve("post_rst0", SYNC_STAGES + 1, 0, 0, 1'b0, 1'b0);
    serve("post_rst3", -1, 0, 0, 1'b0, 1'b0);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
